au_mul_seq: RTL
===============

Name: au_mul_seq

Overview:
- Sequencer that reuses the team's 8-bit ripple arithmetic unit (AU) to compute an unsigned 8x8 multiply by shift-and-add.
- Operation: one AU pass per multiplier bit, a 16-bit product, and a start/busy/done handshake.
- Sits between a requester (control FSM or testbench) and the AU datapath. It is the first multi-cycle consumer of the AU.

Parameters:
- WIDTH, 8, operand width. Must equal the AU width; only 8 is supported. The product is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  8  multiplicand; captured when start is accepted
- b  input  8  multiplier; captured when start is accepted
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; product valid
- product  output  16  unsigned a*b; held until the next accepted start
- zero  output  1  product == 0; qualified by done and the held result

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state = IDLE, busy = 0, done = 0, product = 0, zero = 1. Internal regs mcand, acc_hi, acc_lo and cnt are all 0.
- States: IDLE, CALC, DONE. Encoding comes from the package.
- IDLE
  - If start = 1: capture mcand <= a, acc_hi <= 0, acc_lo <= b, cnt <= 0, then go to CALC.
  - Otherwise stay in IDLE; product and zero keep their values.
- CALC (exactly WIDTH cycles)
  - AU driven combinationally: A = acc_hi, B = mcand, cin = 0.
  - AU op S = AU_OP_ADD (2'b01, D = A+B+cin) when acc_lo[0] = 1. Otherwise S = AU_OP_XFER (2'b00, D = A+cin, cout = 0).
  - Register update: {acc_hi, acc_lo} <= {au_cout, au_d, acc_lo} >> 1, i.e. acc_hi <= {au_cout, au_d[7:1]} and acc_lo <= {au_d[0], acc_lo[7:1]}.
  - cnt increments each cycle; when cnt == WIDTH-1, go to DONE.
- DONE (1 cycle)
  - done = 1, product = {acc_hi, acc_lo}, zero = (product == 0).
  - Product and zero are registered on entry to DONE so they are stable during the pulse. Then go to IDLE.
- Latency: start sampled high at edge N; CALC occupies cycles N+1..N+8; done is high during cycle N+9. The next start is accepted at the earliest at edge N+10 (IDLE).
- start during CALC or DONE: ignored. It is not queued and the operands are not re-captured.
- The AU's Z output is not used for zero; zero is computed over all 16 product bits.
- Carry: au_cout is the ninth sum bit and must enter the shift. Example: 255*255 needs it.
- Reset mid-operation: takes effect on the next edge regardless of state. The result is discarded, done never pulses for the aborted request, and outputs return to their reset values.
- Simultaneous rst and start: rst wins; start is not accepted.
- busy and done are registered outputs, with no combinational path from start.

Decomposition:
- Shared package (au_pkg):
  - AU op constants AU_OP_XFER = 2'b00, AU_OP_ADD = 2'b01, AU_OP_SUB = 2'b10, AU_OP_DEC = 2'b11.
  - State encoding (IDLE/CALC/DONE, 2 bits).
  - AU_WIDTH = 8.
- One sub-module: the existing 8-bit AU, instantiated as u_au, 8-bit data-flow version. The controller contains only the FSM, the counter and the accumulator/shift registers.

Test Plan:
- a=13, b=11, one-cycle start -> busy rises the next cycle; done is a single pulse exactly 9 cycles after the start edge; product = 143 (0x008F); zero = 0.
- a=255, b=255 -> product = 65025 (0xFE01), which exercises au_cout entering acc_hi. a=255, b=1 -> 0x00FF.
- a=0, b=200, then a=200, b=0 -> product = 0 and zero = 1 at done. Both complete in 9 cycles (no early exit).
- start held high throughout a=7, b=9 -> exactly one done with product = 63. Then a=3, b=5 accepted on the first IDLE cycle -> done with 15; no spurious extra done. Operand changes while busy do not affect the result.
- rst asserted in the 4th CALC cycle of a=100, b=100 -> the next cycle shows busy = 0, product = 0, zero = 1 and no done. A fresh a=100, b=100 then yields 10000 (0x2710).
- rst and start high in the same cycle -> remains IDLE with busy = 0 the following cycle.

Source files
------------

// File: rtl/au_pkg.sv
// Shared AU definitions: datapath width, AU op codes and the multiply
// sequencer state encoding.
package au_pkg;

  localparam int AU_WIDTH = 8;

  localparam logic [1:0] AU_OP_XFER = 2'b00;  // D = A + cin, cout = 0
  localparam logic [1:0] AU_OP_ADD  = 2'b01;  // D = A + B + cin
  localparam logic [1:0] AU_OP_SUB  = 2'b10;  // D = A + ~B + cin
  localparam logic [1:0] AU_OP_DEC  = 2'b11;  // D = A + 8'hFF + cin

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } au_state_e;

endpackage

// File: rtl/au_mul_seq_if.sv
// Requester-side bundle of the shift-and-add multiplier, plus debug taps.
interface au_mul_seq_if
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH
);
  // Handshake: start is only looked at while idle (busy = 0); a, b are
  // captured on that edge. busy stays high until done pulses for one
  // cycle, during which product/zero are valid; they then hold.
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic                   zero;
  au_state_e              dbg_state;
  logic                   dbg_au_z;

  modport master (
    output start, a, b,
    input  busy, done, product, zero, dbg_state, dbg_au_z
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, zero, dbg_state, dbg_au_z
  );

endinterface

// File: rtl/au_mul_seq_au.sv
// The 8-bit ripple arithmetic unit, data-flow form.
module au_mul_seq_au
  import au_pkg::*;
(
  input  logic [AU_WIDTH-1:0] a,
  input  logic [AU_WIDTH-1:0] b,
  input  logic                cin,
  input  logic [1:0]          s,
  output logic [AU_WIDTH-1:0] d,
  output logic                cout,
  output logic                z
);

  logic [AU_WIDTH-1:0] bop;
  logic [AU_WIDTH:0]   c;

  // Every op is A + bop + cin; the op only selects the second operand.
  assign bop = (s == AU_OP_XFER) ? '0 :
               (s == AU_OP_ADD)  ? b  :
               (s == AU_OP_SUB)  ? ~b : '1;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < AU_WIDTH; i++) begin : g_bit
      assign d[i]   = a[i] ^ bop[i] ^ c[i];
      assign c[i+1] = (a[i] & bop[i]) | (c[i] & (a[i] ^ bop[i]));
    end
  endgenerate

  assign cout = (s == AU_OP_XFER) ? 1'b0 : c[AU_WIDTH];
  assign z    = (d == '0);

endmodule

// File: rtl/au_mul_seq.sv
// Unsigned WIDTH x WIDTH multiplier: one AU add-or-pass per multiplier
// bit, accumulator shifted right each cycle, 2*WIDTH-bit product.
module au_mul_seq
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH  // must equal AU_WIDTH
)(
  input  logic          clk,
  input  logic          rst,
  au_mul_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  au_state_e            state, next_state;
  logic [WIDTH-1:0]     mcand, acc_hi, acc_lo;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 zero_q;

  logic [1:0]           au_s;
  logic [WIDTH-1:0]     au_d;
  logic                 au_cout;
  logic                 au_z;
  logic [WIDTH-1:0]     shift_hi, shift_lo;

  au_mul_seq_au u_au (
    .a    (acc_hi),
    .b    (mcand),
    .cin  (1'b0),
    .s    (au_s),
    .d    (au_d),
    .cout (au_cout),
    .z    (au_z)
  );

  // The AU carry is the ninth sum bit and shifts in at the top.
  assign shift_hi = {au_cout, au_d[WIDTH-1:1]};
  assign shift_lo = {au_d[0], acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    au_s       = AU_OP_XFER;
    case (state)
      ST_IDLE: if (bus.start) next_state = ST_CALC;
      ST_CALC: begin
        au_s = acc_lo[0] ? AU_OP_ADD : AU_OP_XFER;
        if (cnt == CNT_LAST) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      product_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          mcand  <= bus.a;
          acc_hi <= '0;
          acc_lo <= bus.b;
          cnt    <= '0;
        end
        ST_CALC: begin
          acc_hi <= shift_hi;
          acc_lo <= shift_lo;
          cnt    <= cnt + 1'b1;
          // Register the result on the last step so it is stable under done.
          if (cnt == CNT_LAST) begin
            product_q <= {shift_hi, shift_lo};
            zero_q    <= ({shift_hi, shift_lo} == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == ST_CALC) || (state == ST_DONE);
  assign bus.done      = (state == ST_DONE);
  assign bus.product   = product_q;
  assign bus.zero      = zero_q;
  assign bus.dbg_state = state;
  assign bus.dbg_au_z  = au_z;

endmodule
